// File: rtl/packed_q_bank_pkg.sv
// Shared constants, pointer/count types and helpers for the packed multi-queue FIFO bank.
// Pointer helpers take the live width as an argument so one package serves every configuration.
package packed_q_pkg;

  localparam int unsigned DEF_NUM_OF_Q         = 16;
  localparam int unsigned DEF_DEPTH_EACH_Q     = 4;
  localparam int unsigned DEF_BITS_ADDR_PACK   = $clog2(DEF_NUM_OF_Q);
  localparam int unsigned DEF_BITS_ADDR_EACH_Q = $clog2(DEF_DEPTH_EACH_Q);
  localparam int unsigned DEF_DATA_WIDTH       = 32;

  // Widest per-queue pointer the helpers support; narrower pointers are zero-extended into these.
  localparam int unsigned MAX_PTR_BITS = 16;

  typedef logic [MAX_PTR_BITS-1:0] ptr_t;
  typedef logic [MAX_PTR_BITS:0]   cnt_t;

  function automatic ptr_t next_ptr(input ptr_t ptr, input int unsigned bits);
    ptr_t mask;
    mask = ptr_t'((32'd1 << bits) - 32'd1);
    return (ptr + ptr_t'(1)) & mask;
  endfunction

  function automatic logic is_full(input cnt_t cnt, input int unsigned bits);
    return cnt == cnt_t'(32'd1 << bits);
  endfunction

endpackage

// File: rtl/packed_q_bank_if.sv
// Write / read / flush handshake bundle of the packed queue bank, plus per-queue status.
// master = producer/consumer side, slave = the bank itself.
interface packed_q_bank_if
  import packed_q_pkg::*;
#(
  parameter int BITS_ADDR_PACK = DEF_BITS_ADDR_PACK,
  parameter int NUM_OF_Q       = 2 ** BITS_ADDR_PACK,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
);

  logic                      wr_valid;
  logic [BITS_ADDR_PACK-1:0] wr_q;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      wr_ready;

  logic                      rd_req;
  logic [BITS_ADDR_PACK-1:0] rd_q;
  logic                      rd_ack;
  logic                      rd_data_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic [BITS_ADDR_PACK-1:0] rd_data_q;

  logic                      clr_valid;
  logic [BITS_ADDR_PACK-1:0] clr_q;

  logic [NUM_OF_Q-1:0]       q_empty_vec;
  logic [NUM_OF_Q-1:0]       q_full_vec;

  modport master (
    output wr_valid, wr_q, wr_data, rd_req, rd_q, clr_valid, clr_q,
    input  wr_ready, rd_ack, rd_data_valid, rd_data, rd_data_q, q_empty_vec, q_full_vec
  );

  modport slave (
    input  wr_valid, wr_q, wr_data, rd_req, rd_q, clr_valid, clr_q,
    output wr_ready, rd_ack, rd_data_valid, rd_data, rd_data_q, q_empty_vec, q_full_vec
  );

endinterface

// File: rtl/packed_q_bank_ptrs.sv
// Per-queue read/write pointers and occupancy counts; a flush of one queue overrides any
// read or write firing on that queue in the same cycle.
module packed_q_ptrs
  import packed_q_pkg::*;
#(
  parameter int BITS_ADDR_PACK   = DEF_BITS_ADDR_PACK,
  parameter int NUM_OF_Q         = 2 ** BITS_ADDR_PACK,
  parameter int BITS_ADDR_EACH_Q = DEF_BITS_ADDR_EACH_Q
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        wr_fire,
  input  logic [BITS_ADDR_PACK-1:0]   wr_q,
  input  logic                        rd_fire,
  input  logic [BITS_ADDR_PACK-1:0]   rd_q,
  input  logic                        clr_valid,
  input  logic [BITS_ADDR_PACK-1:0]   clr_q,
  output logic [NUM_OF_Q-1:0]         empty_vec,
  output logic [NUM_OF_Q-1:0]         full_vec,
  output logic [BITS_ADDR_EACH_Q-1:0] rd_ptr,
  output logic [BITS_ADDR_EACH_Q-1:0] wr_ptr
);

  typedef logic [BITS_ADDR_EACH_Q-1:0] q_ptr_t;
  typedef logic [BITS_ADDR_EACH_Q:0]   q_cnt_t;

  q_ptr_t rd_ptr_q [NUM_OF_Q];
  q_ptr_t rd_ptr_d [NUM_OF_Q];
  q_ptr_t wr_ptr_q [NUM_OF_Q];
  q_ptr_t wr_ptr_d [NUM_OF_Q];
  q_cnt_t cnt_q    [NUM_OF_Q];
  q_cnt_t cnt_d    [NUM_OF_Q];

  // Read and write on the same queue cancel in the count but both pointers still move.
  always_comb begin
    for (int i = 0; i < NUM_OF_Q; i++) begin
      // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned (no latch).
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (clr_valid && (clr_q == BITS_ADDR_PACK'(i))) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (wr_fire && (wr_q == BITS_ADDR_PACK'(i))) begin
          wr_ptr_d[i] = q_ptr_t'(next_ptr(ptr_t'(wr_ptr_q[i]), BITS_ADDR_EACH_Q));
          cnt_d[i]    = cnt_d[i] + q_cnt_t'(1);
        end
        if (rd_fire && (rd_q == BITS_ADDR_PACK'(i))) begin
          rd_ptr_d[i] = q_ptr_t'(next_ptr(ptr_t'(rd_ptr_q[i]), BITS_ADDR_EACH_Q));
          cnt_d[i]    = cnt_d[i] - q_cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_OF_Q; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      for (int i = 0; i < NUM_OF_Q; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_Q; i++) begin
      empty_vec[i] = (cnt_q[i] == '0);
      full_vec[i]  = is_full(cnt_t'(cnt_q[i]), BITS_ADDR_EACH_Q);
    end
  end

  assign rd_ptr = rd_ptr_q[rd_q];
  assign wr_ptr = wr_ptr_q[wr_q];

endmodule

// File: rtl/packed_q_bank.sv
// Bank of NUM_OF_Q FIFOs sharing one storage array addressed {queue, ptr}, with a
// combinational handshake and a one-cycle registered, tagged read port.
module packed_q_bank
  import packed_q_pkg::*;
#(
  parameter int BITS_ADDR_PACK   = DEF_BITS_ADDR_PACK,
  parameter int NUM_OF_Q         = 2 ** BITS_ADDR_PACK,
  parameter int BITS_ADDR_EACH_Q = DEF_BITS_ADDR_EACH_Q,
  parameter int DEPTH_EACH_Q     = 2 ** BITS_ADDR_EACH_Q,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH
) (
  input logic            clk,
  input logic            rst_b,
  packed_q_bank_if.slave bus
);

  localparam int ADDR_W      = BITS_ADDR_PACK + BITS_ADDR_EACH_Q;
  localparam int DEPTH_TOTAL = NUM_OF_Q * DEPTH_EACH_Q;

  logic [NUM_OF_Q-1:0]         empty_vec;
  logic [NUM_OF_Q-1:0]         full_vec;
  logic [BITS_ADDR_EACH_Q-1:0] rd_ptr;
  logic [BITS_ADDR_EACH_Q-1:0] wr_ptr;
  logic                        wr_clr_hit;
  logic                        rd_clr_hit;
  logic                        wr_fire;
  logic                        rd_fire;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W-1:0]           rd_addr;

  // Handshake is judged on pre-edge state only: no write-to-read bypass, no read-frees-slot.
  assign wr_clr_hit  = bus.clr_valid && (bus.clr_q == bus.wr_q);
  assign rd_clr_hit  = bus.clr_valid && (bus.clr_q == bus.rd_q);
  assign bus.wr_ready = !full_vec[bus.wr_q] && !wr_clr_hit;
  assign bus.rd_ack   = bus.rd_req && !empty_vec[bus.rd_q] && !rd_clr_hit;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign rd_fire      = bus.rd_ack;

  assign wr_addr = {bus.wr_q, wr_ptr};
  assign rd_addr = {bus.rd_q, rd_ptr};

  packed_q_ptrs #(
    .BITS_ADDR_PACK   (BITS_ADDR_PACK),
    .NUM_OF_Q         (NUM_OF_Q),
    .BITS_ADDR_EACH_Q (BITS_ADDR_EACH_Q)
  ) u_ptrs (
    .clk       (clk),
    .rst_b     (rst_b),
    .wr_fire   (wr_fire),
    .wr_q      (bus.wr_q),
    .rd_fire   (rd_fire),
    .rd_q      (bus.rd_q),
    .clr_valid (bus.clr_valid),
    .clr_q     (bus.clr_q),
    .empty_vec (empty_vec),
    .full_vec  (full_vec),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr)
  );

  assign bus.q_empty_vec = empty_vec;
  assign bus.q_full_vec  = full_vec;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_TOTAL];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  // NOTE: the storage array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_addr] <= bus.wr_data;
    if (rd_fire) ram_rd_q <= mem_q[rd_addr];
  end

  logic                      rd_valid_q;
  logic                      rd_valid_d;
  logic [BITS_ADDR_PACK-1:0] rd_tag_q;
  logic [BITS_ADDR_PACK-1:0] rd_tag_d;

  always_comb begin
    rd_valid_d = rd_fire;
    rd_tag_d   = rd_fire ? bus.rd_q : rd_tag_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // RAM output is masked by the resettable valid flop, so reset forces rd_data to zero at once.
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.rd_data       = rd_valid_q ? ram_rd_q : '0;
  assign bus.rd_data_q     = rd_tag_q;

endmodule

// File: tb/tb_packed_q_bank.sv
// Directed self-checking bench for packed_q_bank: 4 queues x 4 entries x 8 bits.
// Inputs change 1 time unit after a rising edge; outputs are compared away from the edge.
module tb_packed_q_bank;

  localparam int BAP  = 2;
  localparam int BAEQ = 2;
  localparam int DW   = 8;
  localparam int NQ   = 2 ** BAP;

  logic clk;
  logic rst_b;

  int tests_run    = 0;
  int tests_failed = 0;

  packed_q_bank_if #(.BITS_ADDR_PACK(BAP), .NUM_OF_Q(NQ), .DATA_WIDTH(DW)) bus ();

  packed_q_bank #(
    .BITS_ADDR_PACK   (BAP),
    .NUM_OF_Q         (NQ),
    .BITS_ADDR_EACH_Q (BAEQ),
    .DEPTH_EACH_Q     (2 ** BAEQ),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid  = 1'b0;
    bus.rd_req    = 1'b0;
    bus.clr_valid = 1'b0;
  endtask

  task automatic push(input logic [BAP-1:0] q, input logic [DW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_q     = q;
    bus.wr_data  = d;
    #1;
    check("push_ready", bus.wr_ready, 1);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pop_expect(input logic [BAP-1:0] q, input logic [DW-1:0] d);
    bus.rd_req = 1'b1;
    bus.rd_q   = q;
    #1;
    check("pop_ack", bus.rd_ack, 1);
    step();
    bus.rd_req = 1'b0;
    check("pop_valid", bus.rd_data_valid, 1);
    check("pop_data", bus.rd_data, d);
    check("pop_tag", bus.rd_data_q, q);
  endtask

  initial begin
    rst_b         = 1'b0;
    bus.wr_q      = '0;
    bus.wr_data   = '0;
    bus.rd_q      = '0;
    bus.clr_q     = '0;
    idle();
    step();
    step();
    rst_b = 1'b1;
    step();

    // Reset and idle state
    check("rst_empty", bus.q_empty_vec, 4'b1111);
    check("rst_full", bus.q_full_vec, 4'b0000);
    check("rst_valid", bus.rd_data_valid, 0);
    check("rst_data", bus.rd_data, 0);
    check("rst_tag", bus.rd_data_q, 0);
    bus.rd_req = 1'b1;
    bus.rd_q   = 2'd2;
    #1;
    check("idle_rd_ack_q2", bus.rd_ack, 0);
    bus.rd_req = 1'b0;

    // Fill q1 to full, overflow write is dropped, drain in order
    for (int k = 1; k <= 4; k++) push(2'd1, DW'(8'h11 * k));
    check("q1_full", bus.q_full_vec, 4'b0010);
    check("q1_not_empty", bus.q_empty_vec, 4'b1101);
    bus.wr_valid = 1'b1;
    bus.wr_q     = 2'd1;
    bus.wr_data  = 8'h55;
    #1;
    check("q1_overflow_ready", bus.wr_ready, 0);
    step();
    bus.wr_valid = 1'b0;
    check("q1_still_full", bus.q_full_vec, 4'b0010);
    bus.rd_req = 1'b1;
    bus.rd_q   = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("q1_b2b_ack", bus.rd_ack, 1);
      step();
      check("q1_b2b_valid", bus.rd_data_valid, 1);
      check("q1_b2b_data", bus.rd_data, DW'(8'h11 * k));
      check("q1_b2b_tag", bus.rd_data_q, 1);
    end
    #1;
    check("q1_drained_ack", bus.rd_ack, 0);
    check("q1_drained_empty", bus.q_empty_vec, 4'b1111);
    step();
    bus.rd_req = 1'b0;
    check("q1_no_extra_valid", bus.rd_data_valid, 0);

    // Wrap-around on q3: 3 writes, 3 overlapped read+write, 3 reads
    for (int k = 0; k < 3; k++) push(2'd3, DW'(8'hA0 + k));
    for (int k = 0; k < 3; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_q     = 2'd3;
      bus.wr_data  = DW'(8'hA3 + k);
      bus.rd_req   = 1'b1;
      bus.rd_q     = 2'd3;
      #1;
      check("q3_ovl_ready", bus.wr_ready, 1);
      check("q3_ovl_ack", bus.rd_ack, 1);
      step();
      check("q3_ovl_data", bus.rd_data, DW'(8'hA0 + k));
      check("q3_ovl_full", bus.q_full_vec, 4'b0000);
    end
    idle();
    for (int k = 0; k < 3; k++) pop_expect(2'd3, DW'(8'hA3 + k));
    check("q3_empty", bus.q_empty_vec, 4'b1111);

    // Simultaneous read+write on q0 holding two entries
    push(2'd0, 8'h01);
    push(2'd0, 8'h02);
    bus.wr_valid = 1'b1;
    bus.wr_q     = 2'd0;
    bus.wr_data  = 8'h03;
    bus.rd_req   = 1'b1;
    bus.rd_q     = 2'd0;
    #1;
    check("q0_sim_ready", bus.wr_ready, 1);
    check("q0_sim_ack", bus.rd_ack, 1);
    step();
    idle();
    check("q0_sim_data", bus.rd_data, 8'h01);
    pop_expect(2'd0, 8'h02);
    pop_expect(2'd0, 8'h03);
    check("q0_after_sim_empty", bus.q_empty_vec, 4'b1111);

    // Same stimulus on an empty q0: no bypass, count becomes 1
    bus.wr_valid = 1'b1;
    bus.wr_q     = 2'd0;
    bus.wr_data  = 8'h04;
    bus.rd_req   = 1'b1;
    bus.rd_q     = 2'd0;
    #1;
    check("q0_empty_sim_ack", bus.rd_ack, 0);
    check("q0_empty_sim_ready", bus.wr_ready, 1);
    step();
    idle();
    check("q0_empty_sim_valid", bus.rd_data_valid, 0);
    check("q0_one_entry", bus.q_empty_vec, 4'b1110);
    pop_expect(2'd0, 8'h04);
    check("q0_empty_again", bus.q_empty_vec, 4'b1111);

    // Clear q2 (3 entries) with a write to q2 presented and a read on q0
    push(2'd0, 8'hD0);
    push(2'd0, 8'hD1);
    for (int k = 1; k <= 3; k++) push(2'd2, DW'(8'hC0 + k));
    check("pre_clr_empty", bus.q_empty_vec, 4'b1010);
    bus.clr_valid = 1'b1;
    bus.clr_q     = 2'd2;
    bus.wr_valid  = 1'b1;
    bus.wr_q      = 2'd2;
    bus.wr_data   = 8'hEE;
    bus.rd_req    = 1'b1;
    bus.rd_q      = 2'd0;
    #1;
    check("clr_wr_ready", bus.wr_ready, 0);
    check("clr_other_ack", bus.rd_ack, 1);
    step();
    idle();
    check("clr_empty", bus.q_empty_vec, 4'b1110);
    check("clr_q0_data", bus.rd_data, 8'hD0);
    check("clr_q0_tag", bus.rd_data_q, 0);
    push(2'd2, 8'h77);
    pop_expect(2'd2, 8'h77);
    pop_expect(2'd0, 8'hD1);

    // Clear blocks a read of the same queue
    push(2'd2, 8'h55);
    bus.clr_valid = 1'b1;
    bus.clr_q     = 2'd2;
    bus.rd_req    = 1'b1;
    bus.rd_q      = 2'd2;
    #1;
    check("clr_rd_ack", bus.rd_ack, 0);
    step();
    idle();
    check("clr_rd_valid", bus.rd_data_valid, 0);
    check("clr_rd_empty", bus.q_empty_vec, 4'b1111);

    // Async reset pulse while read data is valid
    push(2'd1, 8'h99);
    push(2'd1, 8'h98);
    pop_expect(2'd1, 8'h99);
    rst_b = 1'b0;
    #1;
    check("arst_valid", bus.rd_data_valid, 0);
    check("arst_data", bus.rd_data, 0);
    check("arst_tag", bus.rd_data_q, 0);
    check("arst_empty", bus.q_empty_vec, 4'b1111);
    #4;
    rst_b = 1'b1;
    step();
    check("post_rst_empty", bus.q_empty_vec, 4'b1111);
    check("post_rst_full", bus.q_full_vec, 4'b0000);
    bus.rd_req = 1'b1;
    bus.rd_q   = 2'd1;
    #1;
    check("post_rst_ack", bus.rd_ack, 0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/packed_q_bank.md
# packed_q_bank

Bank of NUM_OF_Q independent FIFOs sharing one data array, each DEPTH_EACH_Q deep, addressed by queue index. It sits directly downstream of the SpMV merge front-end. It owns both the per-queue read/write pointers and occupancy counters and the data storage those pointers index, so consumers see a complete tagged multi-queue FIFO with a registered read port.

## Interface
- BITS_ADDR_PACK, 4, log2 of queue count
- NUM_OF_Q, 2**BITS_ADDR_PACK, number of queues
- BITS_ADDR_EACH_Q, 2, log2 of per-queue depth; must be ≥1
- DEPTH_EACH_Q, 2**BITS_ADDR_EACH_Q, entries per queue
- DATA_WIDTH, 32, payload bits
- clk  in  1  single clock, rising edge
- rst_b  in  1  reset; asynchronous assert, active-low
- wr_valid  in  1  write request
- wr_q  in  BITS_ADDR_PACK  target queue of write
- wr_data  in  DATA_WIDTH  payload
- wr_ready  out  1  combinational: !full[wr_q]
- rd_req  in  1  read request
- rd_q  in  BITS_ADDR_PACK  source queue of read
- rd_ack  out  1  combinational: rd_req & !empty[rd_q]
- rd_data_valid  out  1  registered; high one cycle after an acked read
- rd_data  out  DATA_WIDTH  registered payload
- rd_data_q  out  BITS_ADDR_PACK  registered tag (queue index of rd_data)
- clr_valid  in  1  flush one queue
- clr_q  in  BITS_ADDR_PACK  queue to flush
- q_empty_vec  out  NUM_OF_Q  per-queue empty, registered-state derived
- q_full_vec  out  NUM_OF_Q  per-queue full

## Operation
- Per queue: rd_ptr, wr_ptr (BITS_ADDR_EACH_Q bits, wrap modulo DEPTH_EACH_Q), count (BITS_ADDR_EACH_Q+1 bits, 0..DEPTH_EACH_Q).
- empty[i] = (count[i]==0); full[i] = (count[i]==DEPTH_EACH_Q).
- Storage address = {queue index, ptr}; array depth NUM_OF_Q*DEPTH_EACH_Q. Storage is not reset.
- Write accepted (wr_fire) iff wr_valid & wr_ready: mem[{wr_q,wr_ptr}] <= wr_data; wr_ptr+1; count+1.
- Read accepted (rd_fire) iff rd_ack: read mem[{rd_q,rd_ptr}]; rd_ptr+1; count−1.
- Same queue, both fire: both pointers advance, count unchanged.
- Empty queue: read rejected even when a write to it fires that cycle (no bypass).
- Full queue: write rejected even when a read from it fires that cycle.
- Different queues: fully independent updates.
- No read/write slot collision: a fired read and write to the same queue address distinct slots by construction.
- clr_valid: rd_ptr, wr_ptr, count of clr_q set to 0 next cycle. Has priority over any read/write fire on the same queue that cycle. rd_ack and wr_ready are forced low for clr_q while clr_valid. Other queues are unaffected.
- Read data already in flight when a clear hits its queue is still delivered.

## Timing
- Reset (async, rst_b low): all pointers/counts 0, q_empty_vec all 1, q_full_vec all 0, rd_data_valid 0, rd_data 0, rd_data_q 0.
- wr_ready/rd_ack: same-cycle combinational from current state and inputs.
- Read latency: 1 cycle. rd_fire at edge T gives rd_data_valid=1, rd_data, rd_data_q at T+1. Back-to-back reads sustain 1 per cycle.
- Write-to-read latency: write fires at T, queue is non-empty and readable at T+1, data appears at T+2.
- q_empty_vec/q_full_vec reflect state after the last edge.
- Reset asserted mid-operation discards in-flight read data: rd_data_valid drops immediately.

## Structure
- Package packed_q_pkg: clog2-based width constants, ptr_t/cnt_t typedefs, helper functions next_ptr() and is_full().
- Sub-module packed_q_ptrs: pointer and count array with clear priority. It outputs empty/full vectors and the selected rd_ptr/wr_ptr. The top level adds the storage array, the read-data register and the handshake.
- Storage is written so it infers block RAM with a registered read.

## Test plan
All scenarios use BITS_ADDR_PACK=2, BITS_ADDR_EACH_Q=2, DATA_WIDTH=8.
- Reset then idle: q_empty_vec=4'b1111, q_full_vec=0, rd_data_valid=0; rd_req to q2 gives rd_ack=0.
- Fill q1 with 0x11..0x44: q_full_vec[1]=1 after the 4th write. A 5th write sees wr_ready=0 and is dropped. Four reads return 0x11,0x22,0x33,0x44 with rd_data_q=1 on consecutive cycles.
- Wrap-around: 6 writes/reads interleaved on q3 return data in order; count never exceeds 4.
- Simultaneous read+write on q0 holding 2 entries: count stays 2, FIFO order is preserved. The same stimulus on an empty q0 gives rd_ack=0 and count goes to 1.
- Clear q2 holding 3 entries while a write to q2 is presented: wr_ready=0, next cycle q_empty_vec[2]=1. Concurrent traffic on q0 is unaffected.
- rst_b pulsed low for half a cycle while rd_data_valid=1: valid drops asynchronously and all queues read empty afterwards.
